// File: rtl/enhanced_cu.sv
// Multi-cycle control unit for the enhanced processor: fetch/decode/execute
// sequencing with a memory wait counter, blocking input wait and extended opcodes.
module enhanced_cu #(
    parameter int OPW      = 4,
    parameter int MEM_WAIT = 0
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [OPW-1:0] IR,
    input  logic           Aeq0,
    input  logic           Apos,
    input  logic           Enter,
    output logic           IRload,
    output logic           PCload,
    output logic           JMPmux,
    output logic           Meminst,
    output logic           MemWr,
    output logic           Aload,
    output logic [1:0]     Asel,
    output logic           Sub,
    output logic           Outload,
    output logic           Halt
);

    localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WW-1:0] WLAST = WW'(MEM_WAIT);
    localparam logic [WW-1:0] WONE  = WW'(1);

    localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
    localparam logic [OPW-1:0] OP_STORE = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(3);
    localparam logic [OPW-1:0] OP_IN    = OPW'(4);
    localparam logic [OPW-1:0] OP_JZ    = OPW'(5);
    localparam logic [OPW-1:0] OP_JPOS  = OPW'(6);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(7);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(8);
    localparam logic [OPW-1:0] OP_OUT   = OPW'(9);
    localparam logic [OPW-1:0] OP_CLR   = OPW'(11);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        INWAIT,
        HALT
    } state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic          wdone;

    assign wdone = (wcnt == WLAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        IRload   = 1'b0;
        PCload   = 1'b0;
        JMPmux   = 1'b0;
        Meminst  = 1'b0;
        MemWr    = 1'b0;
        Aload    = 1'b0;
        Asel     = 2'b00;
        Sub      = 1'b0;
        Outload  = 1'b0;
        Halt     = 1'b0;

        // Reset masks every strobe in the cycle it is asserted, whatever the state.
        if (!Reset) begin
            unique case (state)
                FETCH: begin
                    Meminst = 1'b1;
                    if (wdone) begin
                        IRload   = 1'b1;
                        PCload   = 1'b1;
                        wcnt_nx  = '0;
                        state_nx = DECODE;
                    end else begin
                        wcnt_nx = wcnt + WONE;
                    end
                end
                DECODE: state_nx = EXEC;
                EXEC: begin
                    state_nx = FETCH;
                    case (IR)
                        OP_LOAD, OP_STORE: begin
                            if (IR == OP_LOAD) Asel = 2'b10;
                            if (wdone) begin
                                wcnt_nx = '0;
                                if (IR == OP_LOAD) Aload = 1'b1;
                                else               MemWr = 1'b1;
                            end else begin
                                wcnt_nx  = wcnt + WONE;
                                state_nx = EXEC;
                            end
                        end
                        OP_ADD: Aload = 1'b1;
                        OP_SUB: begin
                            Sub   = 1'b1;
                            Aload = 1'b1;
                        end
                        OP_IN: begin
                            Asel = 2'b01;
                            if (Enter) Aload    = 1'b1;
                            else       state_nx = INWAIT;
                        end
                        OP_JZ: begin
                            JMPmux = Aeq0;
                            PCload = Aeq0;
                        end
                        OP_JPOS: begin
                            JMPmux = Apos;
                            PCload = Apos;
                        end
                        OP_HALT: state_nx = HALT;
                        OP_JMP: begin
                            JMPmux = 1'b1;
                            PCload = 1'b1;
                        end
                        OP_OUT: Outload = 1'b1;
                        OP_CLR: begin
                            Asel  = 2'b11;
                            Aload = 1'b1;
                        end
                        default: ;
                    endcase
                end
                INWAIT: begin
                    Asel = 2'b01;
                    if (Enter) begin
                        Aload    = 1'b1;
                        state_nx = FETCH;
                    end
                end
                HALT: Halt = 1'b1;
                default: state_nx = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_enhanced_cu.sv
// Scoreboard bench for enhanced_cu: per-cycle expected control vectors are queued
// as stimulus is applied and compared on the following falling edge.
module tb_enhanced_cu;

    // Packed view: {Halt, Outload, Sub, Asel[1:0], Aload, MemWr, Meminst, JMPmux, PCload, IRload}
    localparam logic [10:0] IRL  = 11'h001;
    localparam logic [10:0] PCL  = 11'h002;
    localparam logic [10:0] JMP  = 11'h004;
    localparam logic [10:0] MI   = 11'h008;
    localparam logic [10:0] MW   = 11'h010;
    localparam logic [10:0] AL   = 11'h020;
    localparam logic [10:0] AIN  = 11'h040;
    localparam logic [10:0] AMEM = 11'h080;
    localparam logic [10:0] AZER = 11'h0C0;
    localparam logic [10:0] SUBM = 11'h100;
    localparam logic [10:0] OUTL = 11'h200;
    localparam logic [10:0] HLT  = 11'h400;
    localparam logic [10:0] FL   = MI | IRL | PCL;
    localparam logic [10:0] NONE = 11'h000;

    typedef struct {
        bit          rst;
        logic [4:0]  ir;
        bit          aeq0;
        bit          apos;
        bit          enter;
        logic [10:0] exp;
    } step_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic [3:0] IR0 = '0;
    logic [4:0] IR2 = '0;
    logic Aeq0 = 1'b0, Apos = 1'b0, Enter = 1'b0;

    logic irl0, pcl0, jmx0, mi0, mw0, al0, sub0, outl0, hlt0;
    logic [1:0] asel0;
    logic irl2, pcl2, jmx2, mi2, mw2, al2, sub2, outl2, hlt2;
    logic [1:0] asel2;

    logic [10:0] o0, o2, obs, e;
    logic [10:0] sb[$];
    int ncmp = 0;
    int nerr = 0;
    bit sel = 1'b0;

    always #5 Clock = ~Clock;

    enhanced_cu #(.OPW(4), .MEM_WAIT(0)) u0 (
        .Clock(Clock), .Reset(Reset), .IR(IR0), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(irl0), .PCload(pcl0), .JMPmux(jmx0), .Meminst(mi0), .MemWr(mw0),
        .Aload(al0), .Asel(asel0), .Sub(sub0), .Outload(outl0), .Halt(hlt0)
    );

    enhanced_cu #(.OPW(5), .MEM_WAIT(2)) u2 (
        .Clock(Clock), .Reset(Reset), .IR(IR2), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(irl2), .PCload(pcl2), .JMPmux(jmx2), .Meminst(mi2), .MemWr(mw2),
        .Aload(al2), .Asel(asel2), .Sub(sub2), .Outload(outl2), .Halt(hlt2)
    );

    assign o0 = {hlt0, outl0, sub0, asel0, al0, mw0, mi0, jmx0, pcl0, irl0};
    assign o2 = {hlt2, outl2, sub2, asel2, al2, mw2, mi2, jmx2, pcl2, irl2};

    function automatic step_t mk(bit r, int ir, bit z, bit p, bit en, logic [10:0] x);
        step_t s;
        s.rst = r; s.ir = 5'(ir); s.aeq0 = z; s.apos = p; s.enter = en; s.exp = x;
        return s;
    endfunction

    task automatic apply(input step_t s);
        Reset = s.rst;
        IR0   = s.ir[3:0];
        IR2   = s.ir;
        Aeq0  = s.aeq0;
        Apos  = s.apos;
        Enter = s.enter;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t st[$];
        sel = 1'b0;
        for (int i = 0; i < 3; i++) st.push_back(mk(1, 0, 0, 0, 0, NONE));
        st.push_back(mk(0, 10, 0, 0, 0, FL));
        st.push_back(mk(0, 10, 0, 0, 0, NONE));
        st.push_back(mk(0, 10, 0, 0, 0, NONE));
        st.push_back(mk(0, 10, 0, 0, 0, FL));
        foreach (st[i]) begin
            @(posedge Clock); #1; apply(st[i]);
            @(negedge Clock); obs = o0; e = sb.pop_front(); ncmp++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL reset step %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_alu();
        step_t st[$];
        sel = 1'b0;
        st.push_back(mk(1, 0, 0, 0, 0, NONE));
        st.push_back(mk(0, 2, 0, 0, 0, FL));
        st.push_back(mk(0, 2, 0, 0, 0, NONE));
        st.push_back(mk(0, 2, 0, 0, 0, AL));
        st.push_back(mk(0, 3, 0, 0, 0, FL));
        st.push_back(mk(0, 3, 0, 0, 0, NONE));
        st.push_back(mk(0, 3, 0, 0, 0, AL | SUBM));
        st.push_back(mk(0, 9, 0, 0, 0, FL));
        st.push_back(mk(0, 9, 0, 0, 0, NONE));
        st.push_back(mk(0, 9, 0, 0, 0, OUTL));
        st.push_back(mk(0, 11, 0, 0, 0, FL));
        st.push_back(mk(0, 11, 0, 0, 0, NONE));
        st.push_back(mk(0, 11, 0, 0, 0, AZER | AL));
        st.push_back(mk(0, 12, 0, 0, 0, FL));
        st.push_back(mk(0, 12, 0, 0, 0, NONE));
        st.push_back(mk(0, 12, 0, 0, 0, NONE));
        st.push_back(mk(0, 2, 0, 0, 0, FL));
        foreach (st[i]) begin
            @(posedge Clock); #1; apply(st[i]);
            @(negedge Clock); obs = o0; e = sb.pop_front(); ncmp++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL alu step %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_memwait();
        step_t st[$];
        sel = 1'b1;
        st.push_back(mk(1, 0, 0, 0, 0, NONE));
        // LOAD: 3 fetch, decode, 3 exec
        st.push_back(mk(0, 0, 0, 0, 0, MI));
        st.push_back(mk(0, 0, 0, 0, 0, MI));
        st.push_back(mk(0, 0, 0, 0, 0, FL));
        st.push_back(mk(0, 0, 0, 0, 0, NONE));
        st.push_back(mk(0, 0, 0, 0, 0, AMEM));
        st.push_back(mk(0, 0, 0, 0, 0, AMEM));
        st.push_back(mk(0, 0, 0, 0, 0, AMEM | AL));
        // STORE
        st.push_back(mk(0, 1, 0, 0, 0, MI));
        st.push_back(mk(0, 1, 0, 0, 0, MI));
        st.push_back(mk(0, 1, 0, 0, 0, FL));
        st.push_back(mk(0, 1, 0, 0, 0, NONE));
        st.push_back(mk(0, 1, 0, 0, 0, NONE));
        st.push_back(mk(0, 1, 0, 0, 0, NONE));
        st.push_back(mk(0, 1, 0, 0, 0, MW));
        // opcode 20 on the 5-bit variant decodes as NOP
        st.push_back(mk(0, 20, 0, 0, 0, MI));
        st.push_back(mk(0, 20, 0, 0, 0, MI));
        st.push_back(mk(0, 20, 0, 0, 0, FL));
        st.push_back(mk(0, 20, 0, 0, 0, NONE));
        st.push_back(mk(0, 20, 0, 0, 0, NONE));
        // reset mid-fetch must clear the wait counter
        st.push_back(mk(0, 2, 0, 0, 0, MI));
        st.push_back(mk(1, 2, 0, 0, 0, NONE));
        st.push_back(mk(0, 2, 0, 0, 0, MI));
        st.push_back(mk(0, 2, 0, 0, 0, MI));
        st.push_back(mk(0, 2, 0, 0, 0, FL));
        st.push_back(mk(0, 2, 0, 0, 0, NONE));
        st.push_back(mk(0, 2, 0, 0, 0, AL));
        st.push_back(mk(0, 2, 0, 0, 0, MI));
        foreach (st[i]) begin
            @(posedge Clock); #1; apply(st[i]);
            @(negedge Clock); obs = o2; e = sb.pop_front(); ncmp++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL memwait step %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_input();
        step_t st[$];
        sel = 1'b0;
        st.push_back(mk(1, 0, 0, 0, 0, NONE));
        st.push_back(mk(0, 4, 0, 0, 0, FL));
        st.push_back(mk(0, 4, 0, 0, 0, NONE));
        st.push_back(mk(0, 4, 0, 0, 0, AIN));
        for (int k = 0; k < 5; k++) st.push_back(mk(0, 4, 0, 0, 0, AIN));
        st.push_back(mk(0, 4, 0, 0, 1, AIN | AL));
        st.push_back(mk(0, 4, 0, 0, 0, FL));
        st.push_back(mk(0, 4, 0, 0, 0, NONE));
        st.push_back(mk(0, 4, 0, 0, 1, AIN | AL));
        st.push_back(mk(0, 10, 0, 0, 0, FL));
        foreach (st[i]) begin
            @(posedge Clock); #1; apply(st[i]);
            @(negedge Clock); obs = o0; e = sb.pop_front(); ncmp++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL input step %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_jumps();
        step_t st[$];
        int    ops [5] = '{5, 5, 6, 6, 8};
        bit    zs  [5] = '{0, 1, 1, 0, 0};
        bit    ps  [5] = '{1, 0, 0, 1, 0};
        bit    tk  [5] = '{0, 1, 0, 1, 1};
        sel = 1'b0;
        st.push_back(mk(1, 0, 0, 0, 0, NONE));
        for (int j = 0; j < 5; j++) begin
            st.push_back(mk(0, ops[j], 0, 0, 0, FL));
            st.push_back(mk(0, ops[j], 0, 0, 0, NONE));
            st.push_back(mk(0, ops[j], zs[j], ps[j], 0, tk[j] ? (JMP | PCL) : NONE));
        end
        st.push_back(mk(0, 10, 1, 1, 0, FL));
        foreach (st[i]) begin
            @(posedge Clock); #1; apply(st[i]);
            @(negedge Clock); obs = o0; e = sb.pop_front(); ncmp++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL jumps step %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_halt();
        step_t st[$];
        sel = 1'b0;
        st.push_back(mk(1, 0, 0, 0, 0, NONE));
        st.push_back(mk(0, 7, 0, 0, 0, FL));
        st.push_back(mk(0, 7, 0, 0, 0, NONE));
        st.push_back(mk(0, 7, 0, 0, 0, NONE));
        for (int k = 0; k < 22; k++) st.push_back(mk(0, k % 12, k[0], k[1], 1, HLT));
        st.push_back(mk(1, 4, 0, 0, 0, NONE));
        st.push_back(mk(0, 4, 0, 0, 0, FL));
        foreach (st[i]) begin
            @(posedge Clock); #1; apply(st[i]);
            @(negedge Clock); obs = o0; e = sb.pop_front(); ncmp++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL halt step %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_inwait();
        step_t st[$];
        sel = 1'b0;
        st.push_back(mk(1, 0, 0, 0, 0, NONE));
        st.push_back(mk(0, 4, 0, 0, 0, FL));
        st.push_back(mk(0, 4, 0, 0, 0, NONE));
        st.push_back(mk(0, 4, 0, 0, 0, AIN));
        st.push_back(mk(0, 4, 0, 0, 0, AIN));
        st.push_back(mk(1, 4, 1, 1, 1, NONE));
        st.push_back(mk(0, 4, 0, 0, 0, FL));
        st.push_back(mk(0, 4, 0, 0, 0, NONE));
        foreach (st[i]) begin
            @(posedge Clock); #1; apply(st[i]);
            @(negedge Clock); obs = o0; e = sb.pop_front(); ncmp++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL reset_inwait step %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_memwait();
        test_input();
        test_jumps();
        test_halt();
        test_reset_inwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
